// File: rtl/cmos_capture_ctrl.sv
// cmos_capture_ctrl: DVP frame sequencer. Skips start-up frames, aligns capture to vsync,
// packs byte pairs into RGB565 words and checks line/frame geometry per frame.
module cmos_capture_ctrl #(
    parameter int unsigned H_ACT       = 1280,
    parameter int unsigned V_ACT       = 720,
    parameter int unsigned SKIP_FRAMES = 10
) (
    input  logic        i_pclk,
    input  logic        rst_n,
    input  logic        i_vsync,
    input  logic        i_href,
    input  logic [7:0]  i_pdata,
    input  logic        i_capture_en,
    input  logic        i_fifo_afull,
    output logic        o_wr_en,
    output logic [15:0] o_wr_data,
    output logic        o_sof,
    output logic        o_eol,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    localparam logic [15:0] H_ACT_W   = 16'(H_ACT);
    localparam logic [15:0] H_LAST_W  = 16'(H_ACT - 1);
    localparam logic [15:0] V_ACT_W   = 16'(V_ACT);
    localparam logic [15:0] SKIP_W    = 16'(SKIP_FRAMES);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;
    localparam bit          SKIP_NONE = (SKIP_FRAMES == 0);

    typedef enum logic [2:0] {StIdle, StSkip, StWaitVs, StActive, StDrop} state_e;

    state_e      state_q, state_d;
    logic        vs_r, vs_rr, href_r, href_rr;
    logic [7:0]  pdata_r;
    logic        vs_rise, href_rise, href_fall;
    logic        word_done, word_ok, skip_last;
    logic [15:0] pix_idx;
    logic        phase;
    logic [7:0]  hi_byte;
    logic [15:0] pix_cnt, line_cnt, skip_cnt;
    logic        err_flag, sof_pend;

    // Register the sensor pins once, plus one more stage for edge detection
    always_ff @(posedge i_pclk) begin
        if (!rst_n) begin
            vs_r    <= 1'b0;
            vs_rr   <= 1'b0;
            href_r  <= 1'b0;
            href_rr <= 1'b0;
            pdata_r <= 8'd0;
        end else begin
            vs_r    <= i_vsync;
            vs_rr   <= vs_r;
            href_r  <= i_href;
            href_rr <= href_r;
            pdata_r <= i_pdata;
        end
    end

    // Edge decode and word completion on the registered pins
    always_comb begin
        vs_rise   = vs_r & ~vs_rr;
        href_rise = href_r & ~href_rr;
        href_fall = ~href_r & href_rr;
        // href rise forces the byte phase and pixel index back to zero
        word_done = href_r & ~href_rise & phase;
        pix_idx   = href_rise ? 16'd0 : pix_cnt;
        // a vsync rise closes the frame first, so that cycle's word is dropped
        word_ok   = word_done & (pix_idx < H_ACT_W) & (state_q == StActive) & ~vs_rise;
        skip_last = (skip_cnt + 16'd1) >= SKIP_W;
        o_busy    = (state_q != StIdle);
    end

    // State register
    always_ff @(posedge i_pclk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state: enable and afull only matter at frame boundaries once capturing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_capture_en) state_d = SKIP_NONE ? StWaitVs : StSkip;
            end
            StSkip: begin
                if (!i_capture_en)             state_d = StIdle;
                else if (vs_rise && skip_last) state_d = StWaitVs;
            end
            StWaitVs: begin
                if (!i_capture_en) state_d = StIdle;
                else if (vs_rise)  state_d = i_fifo_afull ? StDrop : StActive;
            end
            StActive, StDrop: begin
                if (vs_rise) begin
                    if (!i_capture_en)    state_d = StIdle;
                    else if (i_fifo_afull) state_d = StDrop;
                    else                   state_d = StActive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Byte pairing: even byte latched, odd byte completes a word
    always_ff @(posedge i_pclk) begin
        if (!rst_n) begin
            phase   <= 1'b0;
            hi_byte <= 8'd0;
            pix_cnt <= 16'd0;
        end else if (href_r) begin
            if (word_done) begin
                phase   <= 1'b0;
                pix_cnt <= (pix_idx == CNT_MAX) ? CNT_MAX : pix_idx + 16'd1;
            end else begin
                phase   <= 1'b1;
                hi_byte <= pdata_r;
                pix_cnt <= pix_idx;
            end
        end
    end

    // Skip counter: counts vsync rises only while skipping
    always_ff @(posedge i_pclk) begin
        if (!rst_n)                         skip_cnt <= 16'd0;
        else if (state_q != StSkip)         skip_cnt <= 16'd0;
        else if (vs_rise && skip_cnt != CNT_MAX) skip_cnt <= skip_cnt + 16'd1;
    end

    // Frame bookkeeping, geometry checks and registered write/frame outputs
    always_ff @(posedge i_pclk) begin
        if (!rst_n) begin
            line_cnt     <= 16'd0;
            err_flag     <= 1'b0;
            sof_pend     <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_data    <= 16'd0;
            o_sof        <= 1'b0;
            o_eol        <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_frame_cnt  <= 16'd0;
        end else begin
            o_wr_en      <= 1'b0;
            o_sof        <= 1'b0;
            o_eol        <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            if (vs_rise) begin
                // close the running frame, then open the next one
                if (state_q == StActive) begin
                    o_frame_done <= 1'b1;
                    o_frame_err  <= err_flag | (line_cnt != V_ACT_W);
                    o_frame_cnt  <= o_frame_cnt + 16'd1;
                end
                line_cnt <= 16'd0;
                err_flag <= 1'b0;
                sof_pend <= 1'b1;
            end else begin
                if (href_fall) begin
                    if (line_cnt != CNT_MAX) line_cnt <= line_cnt + 16'd1;
                    // short/long line or a dangling odd byte
                    if (pix_cnt != H_ACT_W || phase) err_flag <= 1'b1;
                end
                if (word_done && pix_idx >= H_ACT_W) err_flag <= 1'b1;
                if (word_ok) begin
                    o_wr_en   <= 1'b1;
                    o_wr_data <= {hi_byte, pdata_r};
                    o_sof     <= sof_pend;
                    o_eol     <= (pix_idx == H_LAST_W);
                    sof_pend  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Bench for cmos_capture_ctrl: frame-level vector table, random frames against a
// frame/byte-level reference model, and a mid-line reset sequence.
module tb_cmos_capture_ctrl;

    localparam int H    = 4;
    localparam int V    = 3;
    localparam int SKIP = 2;

    typedef struct packed {
        logic            en;
        logic            afull;
        logic            en_mid;
        logic            pat;
        logic [2:0]      nlines;
        logic [3:0][7:0] lb;
        logic [7:0]      exp_writes;
        logic            exp_done;
        logic            exp_err;
    } frame_vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic        sof;
        logic        eol;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n, vsync, href, en, afull;
    logic [7:0]  pdata;
    logic        wr_en, sof, eol, frame_done, frame_err, busy;
    logic [15:0] wr_data, frame_cnt;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_wr_frame = 0;
    int  skip_seen = 0;
    int  exp_fcnt = 0;
    bit  pend_done = 1'b0;
    bit  pend_err = 1'b0;
    bit  sof_pend_m = 1'b0;
    wr_t exp_q[$];
    frame_vec_t tbl[8];

    always #5 clk = ~clk;

    cmos_capture_ctrl #(
        .H_ACT      (H),
        .V_ACT      (V),
        .SKIP_FRAMES(SKIP)
    ) dut (
        .i_pclk      (clk),
        .rst_n       (rst_n),
        .i_vsync     (vsync),
        .i_href      (href),
        .i_pdata     (pdata),
        .i_capture_en(en),
        .i_fifo_afull(afull),
        .o_wr_en     (wr_en),
        .o_wr_data   (wr_data),
        .o_sof       (sof),
        .o_eol       (eol),
        .o_frame_done(frame_done),
        .o_frame_err (frame_err),
        .o_busy      (busy),
        .o_frame_cnt (frame_cnt)
    );

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, want, $time);
    endfunction

    function automatic frame_vec_t mk(input bit e, input bit a, input bit m, input bit p,
                                      input int nl, input int l0, input int l1, input int l2,
                                      input int ew, input bit ed, input bit ee);
        frame_vec_t v;
        v = '0;
        v.en = e; v.afull = a; v.en_mid = m; v.pat = p;
        v.nlines = 3'(nl);
        v.lb[0] = 8'(l0); v.lb[1] = 8'(l1); v.lb[2] = 8'(l2);
        v.exp_writes = 8'(ew); v.exp_done = ed; v.exp_err = ee;
        return v;
    endfunction

    // byte j of a line yields a write iff it completes a word that fits in the line
    function automatic logic exp_wr(input int j, input bit cap);
        return cap && (j % 2 == 1) && (j / 2 < H);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_sof"}, sof, 0);
        check({tag, "_eol"}, eol, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_err"}, frame_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    // Writes and sof/eol framing, checked against the model's expected word stream
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (wr_en === 1'b1) begin
                n_wr_frame++;
                check("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_data", wr_data, e.data);
                    check("sof", sof, e.sof);
                    check("eol", eol, e.eol);
                end
            end else begin
                check("sof_eol_no_write", {sof, eol}, 0);
            end
        end
    end

    task automatic send_line(input int nb, input bit cap, input bit pat);
        logic [7:0] b, prev;
        wr_t e;
        prev = 8'd0;
        for (int i = 0; i < nb; i++) begin
            b = pat ? ((i % 2 == 1) ? 8'h1F : 8'hF8) : 8'($urandom);
            if (exp_wr(i, cap)) begin
                e.data = {prev, b};
                e.sof  = sof_pend_m;
                e.eol  = (i / 2 == H - 1);
                exp_q.push_back(e);
                sof_pend_m = 1'b0;
            end
            prev  = b;
            href  = 1'b1;
            pdata = b;
            tick();
            if (i > 0) check("wr_en_latency", wr_en, exp_wr(i - 1, cap));
        end
        href  = 1'b0;
        pdata = 8'd0;
        tick();
        if (nb > 0) check("wr_en_latency", wr_en, exp_wr(nb - 1, cap));
        tick();
    endtask

    task automatic run_frame(input frame_vec_t v, input bit use_tbl);
        bit cap, ferr;
        int nl, nb, nw;
        en    = v.en;
        afull = v.afull;
        repeat (3) tick();
        // boundary decision: skip SKIP boundaries after enable, then capture unless afull
        if (!v.en) skip_seen = 0;
        else       skip_seen++;
        cap = v.en && (skip_seen > SKIP) && !v.afull;
        vsync = 1'b1;
        tick();
        check("done_early", frame_done, 0);
        tick();
        exp_fcnt += int'(pend_done);
        check("frame_done", frame_done, pend_done);
        check("frame_err", frame_err, pend_done & pend_err);
        check("frame_cnt", frame_cnt, 32'(exp_fcnt));
        check("busy", busy, v.en);
        vsync = 1'b0;
        repeat (2) tick();
        n_wr_frame = 0;
        sof_pend_m = cap;
        nl   = int'(v.nlines);
        ferr = (nl != V);
        nw   = 0;
        for (int l = 0; l < nl; l++) begin
            if (v.en_mid && l == 1) begin
                en = 1'b0;
                // skipping/waiting drop out at once; capture/drop hold to the boundary
                if (skip_seen <= SKIP) skip_seen = 0;
            end
            nb = int'(v.lb[l]);
            if (nb != 2 * H) ferr = 1'b1;
            nw += (nb / 2 < H) ? nb / 2 : H;
            send_line(nb, cap, v.pat);
        end
        repeat (2) tick();
        check("frame_writes", n_wr_frame, use_tbl ? int'(v.exp_writes) : (cap ? nw : 0));
        pend_done = use_tbl ? v.exp_done : cap;
        pend_err  = use_tbl ? v.exp_err : ferr;
    endtask

    initial begin
        frame_vec_t v;
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; pdata = 8'd0; en = 1'b0; afull = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        //         en af mid pat nl  l0  l1  l2  wr done err
        tbl[0] = mk(1, 0, 0, 0,  3,  8,  8,  8,  0, 0,   0);
        tbl[1] = mk(1, 0, 0, 0,  3,  8,  8,  8,  0, 0,   0);
        tbl[2] = mk(1, 0, 0, 1,  3,  8,  8,  8, 12, 1,   0);
        tbl[3] = mk(1, 0, 0, 0,  3, 10,  9,  8, 12, 1,   1);
        tbl[4] = mk(1, 1, 0, 0,  3,  8,  8,  8,  0, 0,   0);
        tbl[5] = mk(1, 0, 0, 0,  2,  8,  8,  0,  8, 1,   1);
        tbl[6] = mk(1, 0, 1, 0,  3,  8,  8,  8, 12, 1,   0);
        tbl[7] = mk(0, 0, 0, 0,  3,  8,  8,  8,  0, 0,   0);
        for (int t = 0; t < 8; t++) run_frame(tbl[t], 1'b1);

        for (int r = 0; r < 40; r++) begin
            v = '0;
            v.en     = ($urandom_range(0, 9) != 0);
            v.afull  = ($urandom_range(0, 3) == 0);
            v.en_mid = ($urandom_range(0, 7) == 0);
            v.nlines = 3'($urandom_range(2, 4));
            for (int l = 0; l < 4; l++)
                v.lb[l] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(5, 11)) : 8'd8;
            run_frame(v, 1'b0);
        end

        // reach a captured frame, then reset in the middle of an extra line
        for (int k = 0; k <= SKIP; k++) run_frame(mk(1, 0, 0, 0, 3, 8, 8, 8, 0, 0, 0), 1'b0);
        href = 1'b1; pdata = 8'hA5;
        tick();
        pdata = 8'h5A;
        tick();
        rst_n = 1'b0; pdata = 8'h33;
        tick();
        rst_n = 1'b1;
        check_all_zero("midline_reset");
        href = 1'b0; pdata = 8'd0; en = 1'b0;
        repeat (2) tick();
        check("queue_drained", exp_q.size(), 0);
        vsync = 1'b1;
        repeat (2) tick();
        check("post_reset_done", frame_done, 0);
        check("post_reset_frame_cnt", frame_cnt, 0);
        vsync = 1'b0;
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
